// File: rtl/rv32i_pkg.sv
// Shared RV32I execute-stage definitions: datapath widths, ALU op codes,
// branch condition codes and the writeback payload layout.
package rv32i_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned REG_AW  = 5;
    localparam int unsigned ALU_OPW = 4;
    localparam int unsigned F3W     = 3;

    typedef enum logic [ALU_OPW-1:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLL  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_SLT  = 4'b1000,
        ALU_SLTU = 4'b1001
    } alu_op_e;

    typedef enum logic [F3W-1:0] {
        BR_BEQ  = 3'b000,
        BR_BNE  = 3'b001,
        BR_BLT  = 3'b100,
        BR_BGE  = 3'b101,
        BR_BLTU = 3'b110,
        BR_BGEU = 3'b111
    } br_funct3_e;

    typedef struct packed {
        logic [XLEN-1:0]   result;
        logic [REG_AW-1:0] rd;
        logic              rd_we;
    } wb_t;

endpackage

// File: rtl/rv32i_ex_stage_if.sv
// Issue, writeback, flush and redirect signals of the execute stage.
// The stage itself connects through the slave modport.
interface rv32i_ex_stage_if;
    import rv32i_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [ALU_OPW-1:0]    in_alu_op;
    logic [XLEN-1:0]       in_pc;
    logic [XLEN-1:0]       in_rs1_data;
    logic [XLEN-1:0]       in_rs2_data;
    logic [XLEN-1:0]       in_imm;
    logic [REG_AW-1:0]     in_rs1_addr;
    logic [REG_AW-1:0]     in_rs2_addr;
    logic [REG_AW-1:0]     in_rd;
    logic                  in_rd_we;
    logic                  in_use_pc;
    logic                  in_use_imm;
    logic                  in_is_branch;
    logic                  in_is_jal;
    logic                  in_is_jalr;
    logic [F3W-1:0]        in_br_funct3;
    logic                  flush;
    logic                  out_valid;
    logic                  out_ready;
    logic [XLEN-1:0]       out_result;
    logic [REG_AW-1:0]     out_rd;
    logic                  out_rd_we;
    logic                  redirect_valid;
    logic [XLEN-1:0]       redirect_pc;

    modport master (
        output in_valid, in_alu_op, in_pc, in_rs1_data, in_rs2_data, in_imm,
               in_rs1_addr, in_rs2_addr, in_rd, in_rd_we, in_use_pc, in_use_imm,
               in_is_branch, in_is_jal, in_is_jalr, in_br_funct3, flush, out_ready,
        input  in_ready, out_valid, out_result, out_rd, out_rd_we,
               redirect_valid, redirect_pc
    );

    modport slave (
        input  in_valid, in_alu_op, in_pc, in_rs1_data, in_rs2_data, in_imm,
               in_rs1_addr, in_rs2_addr, in_rd, in_rd_we, in_use_pc, in_use_imm,
               in_is_branch, in_is_jal, in_is_jalr, in_br_funct3, flush, out_ready,
        output in_ready, out_valid, out_result, out_rd, out_rd_we,
               redirect_valid, redirect_pc
    );

endinterface

// File: rtl/rv32i_alu.sv
// Combinational RV32I integer ALU; undefined op codes produce zero.
module rv32i_alu import rv32i_pkg::*; (
    input  alu_op_e         op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result
);

    logic [4:0] shamt;

    assign shamt = b[4:0];

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_SLL:  result = a << shamt;
            ALU_SRL:  result = a >> shamt;
            ALU_SRA:  result = $signed(a) >>> shamt;
            ALU_SLT:  result = XLEN'($signed(a) < $signed(b));
            ALU_SLTU: result = XLEN'(a < b);
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/rv32i_ex_stage.sv
// RV32I execute stage: operand bypass from its own output register, ALU,
// branch/jump resolution, one-deep registered writeback with valid/ready.
module rv32i_ex_stage #(
    parameter bit FWD_EN = 1'b1
) (
    input logic             clk,
    input logic             rst,
    rv32i_ex_stage_if.slave ex
);
    import rv32i_pkg::*;

    wb_t             wb_q;
    wb_t             wb_d;
    logic            valid_q;
    logic            redir_q;
    logic [XLEN-1:0] redir_pc_q;

    logic            accept_c;
    logic            br_taken;
    logic            redir_c;
    logic            is_jump;
    logic [XLEN-1:0] rs1_f;
    logic [XLEN-1:0] rs2_f;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] target;

    assign ex.in_ready = !valid_q || ex.out_ready;
    assign accept_c    = ex.in_valid && ex.in_ready && !ex.flush;
    assign is_jump     = ex.in_is_jal || ex.in_is_jalr;

    // Bypass the result still sitting in the output register
    always_comb begin
        rs1_f = ex.in_rs1_data;
        rs2_f = ex.in_rs2_data;
        if (FWD_EN && valid_q && wb_q.rd_we && (wb_q.rd == ex.in_rs1_addr)) rs1_f = wb_q.result;
        if (FWD_EN && valid_q && wb_q.rd_we && (wb_q.rd == ex.in_rs2_addr)) rs2_f = wb_q.result;
    end

    assign alu_a = ex.in_use_pc  ? ex.in_pc  : rs1_f;
    assign alu_b = ex.in_use_imm ? ex.in_imm : rs2_f;

    rv32i_alu u_alu (
        .op     (alu_op_e'(ex.in_alu_op)),
        .a      (alu_a),
        .b      (alu_b),
        .result (alu_res)
    );

    always_comb begin
        br_taken = 1'b0;
        case (br_funct3_e'(ex.in_br_funct3))
            BR_BEQ:  br_taken = (rs1_f == rs2_f);
            BR_BNE:  br_taken = (rs1_f != rs2_f);
            BR_BLT:  br_taken = ($signed(rs1_f) <  $signed(rs2_f));
            BR_BGE:  br_taken = ($signed(rs1_f) >= $signed(rs2_f));
            BR_BLTU: br_taken = (rs1_f <  rs2_f);
            BR_BGEU: br_taken = (rs1_f >= rs2_f);
            default: br_taken = 1'b0;
        endcase
    end

    always_comb begin
        target = ex.in_pc + ex.in_imm;
        if (ex.in_is_jalr) target = (rs1_f + ex.in_imm) & ~XLEN'(1);
        redir_c      = accept_c && ((ex.in_is_branch && br_taken) || is_jump);
        wb_d.result  = is_jump ? (ex.in_pc + XLEN'(4)) : alu_res;
        wb_d.rd      = ex.in_rd;
        wb_d.rd_we   = ex.in_rd_we && (ex.in_rd != '0) && !ex.in_is_branch;
    end

    // Payload only moves on accept, so it is frozen for the whole stall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= 1'b0;
            wb_q       <= '0;
            redir_q    <= 1'b0;
            redir_pc_q <= '0;
        end else begin
            redir_q <= redir_c;
            if (redir_c) redir_pc_q <= target;
            if (accept_c) begin
                valid_q <= 1'b1;
                wb_q    <= wb_d;
            end else if (ex.flush || ex.out_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign ex.out_valid      = valid_q;
    assign ex.out_result     = wb_q.result;
    assign ex.out_rd         = wb_q.rd;
    assign ex.out_rd_we      = wb_q.rd_we;
    assign ex.redirect_valid = redir_q;
    assign ex.redirect_pc    = redir_pc_q;

endmodule

// File: tb/tb_rv32i_ex_stage.sv
// Self-checking bench for rv32i_ex_stage: directed table, hand sequences for
// forwarding/backpressure/flush/reset, and random traffic against a model.
module tb_rv32i_ex_stage;
    import rv32i_pkg::*;

    localparam bit FWD = 1'b1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rv32i_ex_stage_if ex();

    rv32i_ex_stage #(.FWD_EN(FWD)) dut (
        .clk (clk),
        .rst (rst),
        .ex  (ex)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] pc, rs1, rs2, imm;
        logic [4:0]  a1, a2, rd;
        logic        rd_we, use_pc, use_imm, is_br, is_jal, is_jalr;
        logic [2:0]  f3;
    } ins_t;

    typedef struct {
        ins_t        i;
        logic [31:0] res;
        logic        we;
        logic        rv;
        logic [31:0] rpc;
    } vec_t;

    int n_chk  = 0;
    int n_fail = 0;

    logic        m_valid, m_we, m_rv;
    logic [31:0] m_res, m_rpc;
    logic [4:0]  m_rd;

    vec_t tbl[23];
    ins_t idle;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic ins_t mk(input logic [3:0] op, input logic [31:0] pc, r1, r2, imm,
                                input logic [4:0] rd, input logic we, upc, uimm, br,
                                input logic [2:0] f3, input logic jal, jalr);
        ins_t t;
        t.op = op; t.pc = pc; t.rs1 = r1; t.rs2 = r2; t.imm = imm;
        t.a1 = 5'd1; t.a2 = 5'd2; t.rd = rd; t.rd_we = we;
        t.use_pc = upc; t.use_imm = uimm; t.is_br = br; t.f3 = f3;
        t.is_jal = jal; t.is_jalr = jalr;
        return t;
    endfunction

    function automatic vec_t vc(input ins_t i, input logic [31:0] res, input logic we,
                                input logic rv, input logic [31:0] rpc);
        vec_t v;
        v.i = i; v.res = res; v.we = we; v.rv = rv; v.rpc = rpc;
        return v;
    endfunction

    // Reference ALU from the instruction-set definitions
    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, b);
        int unsigned sh;
        sh = b % 32;
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return a << sh;
            4'd6: return a >> sh;
            4'd7: return a[31] ? ~((~a) >> sh) : (a >> sh);
            4'd8: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            4'd9: return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic ref_taken(input logic [2:0] f3, input logic [31:0] a, b);
        case (f3)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return int'(a) <  int'(b);
            3'd5: return int'(a) >= int'(b);
            3'd6: return a <  b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] ref_fwd(input logic [4:0] addr, input logic [31:0] data);
        return (FWD && m_valid && m_we && m_rd == addr) ? m_res : data;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_we = 0; m_rv = 0; m_res = 0; m_rpc = 0; m_rd = 0;
    endtask

    task automatic drive(input ins_t i, input logic v, input logic ordy, input logic fl);
        ex.in_valid = v; ex.in_alu_op = i.op; ex.in_pc = i.pc;
        ex.in_rs1_data = i.rs1; ex.in_rs2_data = i.rs2; ex.in_imm = i.imm;
        ex.in_rs1_addr = i.a1; ex.in_rs2_addr = i.a2; ex.in_rd = i.rd;
        ex.in_rd_we = i.rd_we; ex.in_use_pc = i.use_pc; ex.in_use_imm = i.use_imm;
        ex.in_is_branch = i.is_br; ex.in_is_jal = i.is_jal; ex.in_is_jalr = i.is_jalr;
        ex.in_br_funct3 = i.f3; ex.flush = fl; ex.out_ready = ordy;
    endtask

    task automatic check_outs();
        chk("out_valid", ex.out_valid, m_valid);
        chk("out_result", ex.out_result, m_res);
        chk("out_rd", ex.out_rd, m_rd);
        chk("out_rd_we", ex.out_rd_we, m_we);
        chk("redirect_valid", ex.redirect_valid, m_rv);
        chk("redirect_pc", ex.redirect_pc, m_rpc);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, ex.out_valid, 0);
        chk({tag, "_result"}, ex.out_result, 0);
        chk({tag, "_rd"}, ex.out_rd, 0);
        chk({tag, "_rd_we"}, ex.out_rd_we, 0);
        chk({tag, "_redir"}, ex.redirect_valid, 0);
        chk({tag, "_rpc"}, ex.redirect_pc, 0);
        chk({tag, "_in_ready"}, ex.in_ready, 1);
    endtask

    // One cycle: drive at posedge+1, check in_ready, advance model, check at next posedge+1
    task automatic step(input ins_t i, input logic v, input logic ordy, input logic fl);
        logic er, acc, jmp;
        logic [31:0] r1, r2, a, b;
        drive(i, v, ordy, fl);
        #1;
        er = !m_valid || ordy;
        chk("in_ready", ex.in_ready, er);
        acc = v && er && !fl;
        r1 = ref_fwd(i.a1, i.rs1);
        r2 = ref_fwd(i.a2, i.rs2);
        a  = i.use_pc  ? i.pc  : r1;
        b  = i.use_imm ? i.imm : r2;
        jmp = acc && ((i.is_br && ref_taken(i.f3, r1, r2)) || i.is_jal || i.is_jalr);
        @(posedge clk);
        if (acc) begin
            m_valid = 1;
            m_res   = (i.is_jal || i.is_jalr) ? i.pc + 32'd4 : ref_alu(i.op, a, b);
            m_rd    = i.rd;
            m_we    = i.rd_we && (i.rd != 0) && !i.is_br;
        end else begin
            m_valid = fl ? 1'b0 : (m_valid && !ordy);
        end
        m_rv = jmp;
        if (jmp) m_rpc = i.is_jalr ? ((r1 + i.imm) & 32'hFFFF_FFFE) : i.pc + i.imm;
        #1;
        check_outs();
    endtask

    function automatic ins_t rand_ins();
        ins_t t;
        int k;
        k = $urandom_range(0, 9);
        t.op = 4'($urandom_range(0, 15));
        t.pc = $urandom & 32'hFFFF_FFFC;
        t.rs1 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 8)) : $urandom;
        t.rs2 = ($urandom_range(0, 3) == 0) ? t.rs1 : $urandom;
        t.imm = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
        t.a1 = 5'($urandom_range(0, 3));
        t.a2 = 5'($urandom_range(0, 3));
        t.rd = 5'($urandom_range(0, 3));
        t.rd_we = 1'($urandom_range(0, 1));
        t.use_pc = 1'($urandom_range(0, 1));
        t.use_imm = 1'($urandom_range(0, 1));
        t.f3 = 3'($urandom_range(0, 7));
        t.is_br = (k == 6 || k == 7);
        t.is_jal = (k == 8);
        t.is_jalr = (k == 9);
        return t;
    endfunction

    initial begin
        ins_t x, y;
        idle = mk(4'd0, 0, 0, 0, 0, 5'd0, 0, 0, 0, 0, 3'd0, 0, 0);

        tbl[0]  = vc(mk(4'd0, 32'h100, 10, 20, 0, 5'd3, 1, 0, 0, 0, 3'd0, 0, 0), 30, 1, 0, 0);
        tbl[1]  = vc(mk(4'd1, 32'h100, 5, 7, 0, 5'd3, 1, 0, 0, 0, 3'd0, 0, 0), 32'hFFFF_FFFE, 1, 0, 0);
        tbl[2]  = vc(mk(4'd2, 32'h100, 32'hF0F0_F0F0, 32'hFF00_FF00, 0, 5'd3, 1, 0, 0, 0, 3'd0, 0, 0), 32'hF000_F000, 1, 0, 0);
        tbl[3]  = vc(mk(4'd3, 32'h100, 32'h0F, 32'hF0, 0, 5'd3, 1, 0, 0, 0, 3'd0, 0, 0), 32'hFF, 1, 0, 0);
        tbl[4]  = vc(mk(4'd4, 32'h100, 32'hFFFF_0000, 32'h0FF0_0FF0, 0, 5'd3, 1, 0, 0, 0, 3'd0, 0, 0), 32'hF00F_0FF0, 1, 0, 0);
        tbl[5]  = vc(mk(4'd5, 32'h100, 1, 32'h3F, 0, 5'd3, 1, 0, 0, 0, 3'd0, 0, 0), 32'h8000_0000, 1, 0, 0);
        tbl[6]  = vc(mk(4'd6, 32'h100, 32'h8000_0000, 4, 0, 5'd3, 1, 0, 0, 0, 3'd0, 0, 0), 32'h0800_0000, 1, 0, 0);
        tbl[7]  = vc(mk(4'd7, 32'h100, 32'h8000_0000, 32'h24, 0, 5'd3, 1, 0, 0, 0, 3'd0, 0, 0), 32'hF800_0000, 1, 0, 0);
        tbl[8]  = vc(mk(4'd8, 32'h100, 32'hFFFF_FFFF, 1, 0, 5'd3, 1, 0, 0, 0, 3'd0, 0, 0), 1, 1, 0, 0);
        tbl[9]  = vc(mk(4'd9, 32'h100, 32'hFFFF_FFFF, 1, 0, 5'd3, 1, 0, 0, 0, 3'd0, 0, 0), 0, 1, 0, 0);
        tbl[10] = vc(mk(4'd15, 32'h100, 3, 4, 0, 5'd3, 1, 0, 0, 0, 3'd0, 0, 0), 0, 1, 0, 0);
        tbl[11] = vc(mk(4'd0, 32'h100, 32'hFFFF_FFFF, 32'h77, 2, 5'd3, 1, 0, 1, 0, 3'd0, 0, 0), 1, 1, 0, 0);
        tbl[12] = vc(mk(4'd0, 32'h100, 5, 6, 32'h20, 5'd3, 1, 1, 1, 0, 3'd0, 0, 0), 32'h120, 1, 0, 0);
        tbl[13] = vc(mk(4'd0, 32'h100, 10, 20, 0, 5'd0, 1, 0, 0, 0, 3'd0, 0, 0), 30, 0, 0, 0);
        tbl[14] = vc(mk(4'd0, 32'hFFFF_FFFC, 1, 2, 8, 5'd3, 1, 0, 0, 0, 3'd0, 1, 0), 0, 1, 1, 32'h4);
        tbl[15] = vc(mk(4'd0, 32'h100, 32'hFFFF_FFFF, 1, 32'h20, 5'd3, 1, 0, 0, 1, 3'd4, 0, 0), 0, 0, 1, 32'h120);
        tbl[16] = vc(mk(4'd0, 32'h100, 32'hFFFF_FFFF, 1, 32'h20, 5'd3, 1, 0, 0, 1, 3'd6, 0, 0), 0, 0, 0, 0);
        tbl[17] = vc(mk(4'd0, 32'h40, 5, 5, 32'h10, 5'd3, 1, 0, 0, 1, 3'd0, 0, 0), 10, 0, 1, 32'h50);
        tbl[18] = vc(mk(4'd0, 32'h100, 32'hFFFF_FFFF, 1, 32'h20, 5'd3, 1, 0, 0, 1, 3'd7, 0, 0), 0, 0, 1, 32'h120);
        tbl[19] = vc(mk(4'd0, 32'h100, 32'hFFFF_FFFF, 1, 32'h20, 5'd3, 1, 0, 0, 1, 3'd5, 0, 0), 0, 0, 0, 0);
        tbl[20] = vc(mk(4'd0, 32'h100, 5, 5, 32'h20, 5'd3, 1, 0, 0, 1, 3'd2, 0, 0), 10, 0, 0, 0);
        tbl[21] = vc(mk(4'd0, 32'h200, 32'h1001, 0, 4, 5'd3, 1, 0, 0, 0, 3'd0, 0, 1), 32'h204, 1, 1, 32'h1004);
        tbl[22] = vc(mk(4'd0, 32'h300, 5, 6, 32'hFFFF_FFF8, 5'd3, 1, 0, 0, 1, 3'd1, 0, 0), 11, 0, 1, 32'h2F8);

        // Asynchronous reset, checked before any clock edge
        rst = 1'b1;
        drive(idle, 0, 1, 0);
        model_reset();
        #1;
        check_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed table
        for (int k = 0; k < 23; k++) begin
            step(tbl[k].i, 1, 1, 0);
            chk($sformatf("tbl%0d_result", k), ex.out_result, tbl[k].res);
            chk($sformatf("tbl%0d_rd_we", k), ex.out_rd_we, tbl[k].we);
            chk($sformatf("tbl%0d_redir", k), ex.redirect_valid, tbl[k].rv);
            if (tbl[k].rv) chk($sformatf("tbl%0d_rpc", k), ex.redirect_pc, tbl[k].rpc);
        end
        step(idle, 0, 1, 0);
        chk("redirect_one_cycle", ex.redirect_valid, 0);
        chk("redirect_pc_hold", ex.redirect_pc, 32'h2F8);

        // Forwarding from the output register, and no forwarding for rd=0
        x = mk(4'd2, 0, 32'h0F0F_0F0F, 32'hFFFF_FFFF, 0, 5'd5, 1, 0, 0, 0, 3'd0, 0, 0);
        y = mk(4'd4, 0, 32'hDEAD_BEEF, 0, 32'h00FF_00FF, 5'd6, 1, 0, 1, 0, 3'd0, 0, 0);
        y.a1 = 5'd5;
        step(x, 1, 1, 0);
        step(y, 1, 1, 0);
        chk("fwd_xor", ex.out_result, 32'h0FF0_0FF0);
        x.rd = 5'd0;
        y.a1 = 5'd0;
        step(x, 1, 1, 0);
        step(y, 1, 1, 0);
        chk("fwd_rd0_stale", ex.out_result, 32'hDE52_BE10);

        // Backpressure: three stalled cycles, then drain and accept together
        x = mk(4'd0, 0, 100, 1, 0, 5'd7, 1, 0, 0, 0, 3'd0, 0, 0);
        y = mk(4'd1, 0, 50, 8, 0, 5'd8, 1, 0, 0, 0, 3'd0, 0, 0);
        step(x, 1, 1, 0);
        for (int c = 0; c < 3; c++) begin
            step(y, 1, 0, 0);
            chk("bp_in_ready", ex.in_ready, 0);
            chk("bp_frozen", ex.out_result, 101);
            chk("bp_frozen_rd", ex.out_rd, 7);
        end
        step(y, 1, 1, 0);
        chk("bp_release", ex.out_result, 42);

        // Redirect pulses once even while the output is stalled
        x = mk(4'd0, 32'h400, 0, 0, 32'h40, 5'd4, 1, 0, 0, 0, 3'd0, 1, 0);
        step(x, 1, 1, 0);
        chk("jal_redir", ex.redirect_valid, 1);
        step(y, 1, 0, 0);
        chk("jal_redir_drop", ex.redirect_valid, 0);
        chk("jal_rpc_hold", ex.redirect_pc, 32'h440);

        // Flush while stalled, then flush beating an incoming instruction
        step(y, 1, 0, 1);
        chk("flush_stall", ex.out_valid, 0);
        step(x, 1, 1, 0);
        step(y, 1, 1, 1);
        chk("flush_drop_valid", ex.out_valid, 0);
        chk("flush_drop_result", ex.out_result, 32'h404);
        chk("flush_no_redir", ex.redirect_valid, 0);

        // Reset in the middle of a stall, between clock edges
        step(x, 1, 1, 0);
        step(y, 1, 0, 0);
        #1;
        rst = 1'b1;
        #1;
        model_reset();
        check_zero("rst_mid");
        @(posedge clk);
        #1;
        check_zero("rst_hold");
        rst = 1'b0;
        step(idle, 0, 1, 0);
        chk("rst_no_redir", ex.redirect_valid, 0);

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            step(rand_ins(), ($urandom_range(0, 4) != 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 19) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
